// File: rtl/clog2_engine_pkg.sv
// Shared types and sizing helpers for the run-time clog2/bit-width engine.
package clog2_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } clog2_engine_state_t;

  // Width of a field that can hold any value 0..dw.
  function automatic int clog2_res_w(input int dw);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(dw + 1)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clog2_engine_if.sv
// Operand/result handshake bundle for clog2_engine.
interface clog2_engine_if
  import clog2_engine_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = clog2_res_w(DW)
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_n;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_clog2;
  logic [RW-1:0] out_bits;
  logic          out_pow2;
  logic          out_zero;

  modport slave (
    input  in_valid, in_n, out_ready,
    output in_ready, out_valid, out_clog2, out_bits, out_pow2, out_zero
  );

  modport master (
    output in_valid, in_n, out_ready,
    input  in_ready, out_valid, out_clog2, out_bits, out_pow2, out_zero
  );

endinterface

// File: rtl/clog2_engine.sv
// Iterative ceil(log2(n)) / bit-width / power-of-two engine, one shift per clock.
module clog2_engine
  import clog2_engine_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  clog2_engine_if.slave bus
);

  localparam int RW = clog2_res_w(DW);

  clog2_engine_state_t state_q, state_d;
  logic [DW-1:0]       num_q, num_d;
  logic [RW-1:0]       cnt_q, cnt_d;
  logic                pow2_q, pow2_d;
  logic                zero_q, zero_d;

  logic [DW-1:0]       n_minus1;
  assign n_minus1 = bus.in_n - {{(DW-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      pow2_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      pow2_q  <= pow2_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    pow2_d  = pow2_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // n-1 wraps for n=0; the zero flag keeps that value from ever being shifted.
          num_d   = n_minus1;
          cnt_d   = '0;
          pow2_d  = (bus.in_n != '0) && ((bus.in_n & n_minus1) == '0);
          zero_d  = (bus.in_n == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (zero_q || (num_q == '0)) begin
          state_d = DONE;
        end else begin
          num_d = num_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_clog2 = cnt_q;
  // Bit width equals clog2 except at exact powers of two, where it is one more.
  assign bus.out_bits  = zero_q ? '0 : (pow2_q ? cnt_q + 1'b1 : cnt_q);
  assign bus.out_pow2  = pow2_q;
  assign bus.out_zero  = zero_q;

endmodule
